// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: state encoding and default widths shared by the timer control block
package timer_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, CLEAR, RUN} timer_state_t;
   localparam int PRESCALE_W_DEF = 8;
   localparam int WRAP_W_DEF = 8;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock by prescale_q+1, restarting from 0 whenever held
module timer_prescaler
   import timer_ctrl_pkg::*;
#(
   parameter int PRESCALE_W = PRESCALE_W_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  hold,
   input  logic [PRESCALE_W-1:0] prescale_q,
   output logic                  tick
);
   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   assign tick = pre_cnt_q == prescale_q;
   assign pre_cnt_d = (hold || tick) ? '0 : pre_cnt_q + 1'b1;
   always_ff @(posedge clock) pre_cnt_q <= reset ? '0 : pre_cnt_d;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled enable, clear pulse and one-shot/periodic control for a 16-bit up-counter
module timer_ctrl
   import timer_ctrl_pkg::*;
#(
   parameter int PRESCALE_W = PRESCALE_W_DEF,
   parameter int WRAP_W     = WRAP_W_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  oneshot,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  count_tc,
   input  logic                  irq_ack,
   output logic                  count_en,
   output logic                  cnt_clear,
   output logic                  busy,
   output logic                  done,
   output logic                  irq,
   output logic [WRAP_W-1:0]     wrap_cnt
);
   timer_state_t          state_q, state_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [WRAP_W-1:0]     wrap_q, wrap_d;
   logic                  mode_q, mode_d, irq_q, irq_d, done_q, done_d;
   logic                  go, tc, relatch, tick;
   assign go      = start & ~stop;
   assign tc      = (state_q == RUN) & count_tc;
   assign relatch = go & (state_q != CLEAR);
   // prescaler restarts on any entry to or exit from RUN, so it reads 0 throughout CLEAR
   timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clock      (clock),
      .reset      (reset),
      .hold       ((state_q != RUN) || (state_d != RUN)),
      .prescale_q (prescale_q),
      .tick       (tick)
   );
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = go ? CLEAR : IDLE;
         CLEAR:   state_d = stop ? IDLE : RUN;
         RUN:     state_d = stop ? IDLE : go ? CLEAR : (tc && mode_q) ? IDLE : RUN;
         default: state_d = IDLE;
      endcase
      done_d     = tc & mode_q & ~stop & ~start;
      prescale_d = relatch ? prescale : prescale_q;
      mode_d     = relatch ? oneshot : mode_q;
      wrap_d     = relatch ? '0 : (tc && wrap_q != '1) ? wrap_q + 1'b1 : wrap_q;
      irq_d      = tc | (irq_q & ~irq_ack);
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         prescale_q <= '0;
         mode_q     <= 1'b0;
         wrap_q     <= '0;
         irq_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         prescale_q <= prescale_d;
         mode_q     <= mode_d;
         wrap_q     <= wrap_d;
         irq_q      <= irq_d;
         done_q     <= done_d;
      end
   end
   assign count_en  = (state_q == RUN) & tick;
   assign cnt_clear = state_q == CLEAR;
   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign irq       = irq_q;
   assign wrap_cnt  = wrap_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scoreboard bench for timer_ctrl driving a 16-bit up-counter
module tb_timer_ctrl;
   logic        clock = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, oneshot = 1'b0, irq_ack = 1'b0;
   logic [7:0]  prescale = 8'd0;
   logic        count_tc, count_en, cnt_clear, busy, done, irq;
   logic [7:0]  wrap_cnt;
   logic [15:0] cnt;
   logic [15:0] load_val = 16'hFFFF;
   logic        load = 1'b0;
   int checks = 0, errors = 0, en_seen = 0, clr_seen = 0, done_seen = 0, tc_seen = 0;
   int e0, d0, c0, t0, n;
   typedef struct {string tag; logic [31:0] val;} exp_t;
   exp_t sb[$];
   always #5 clock = ~clock;
   timer_ctrl dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .oneshot(oneshot),
      .prescale(prescale), .count_tc(count_tc), .irq_ack(irq_ack), .count_en(count_en),
      .cnt_clear(cnt_clear), .busy(busy), .done(done), .irq(irq), .wrap_cnt(wrap_cnt)
   );
   // counter under control; load lets the bench jump straight to terminal count
   always_ff @(posedge clock)
      if (load) cnt <= load_val;
      else if (reset || cnt_clear) cnt <= '0;
      else if (count_en) cnt <= cnt + 16'd1;
   assign count_tc = count_en & (cnt == 16'hFFFF);
   always @(negedge clock) begin
      if (count_en) en_seen++;
      if (cnt_clear) clr_seen++;
      if (done) done_seen++;
      if (count_tc) tc_seen++;
   end
   task automatic step(int k);
      repeat (k) begin
         @(posedge clock);
         #1;
      end
   endtask
   task automatic push(string tag, logic [31:0] v);
      sb.push_back('{tag, v});
   endtask
   task automatic check(logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty observed=%0h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask
   function automatic logic [31:0] outs();
      return {19'd0, count_en, cnt_clear, busy, done, irq, wrap_cnt};
   endfunction
   function automatic logic [31:0] mk(logic en, logic clr, logic b, logic d, logic i, logic [7:0] w);
      return {19'd0, en, clr, b, d, i, w};
   endfunction
   task automatic wait_tc(string tag, int max);
      int k = 0;
      while (count_tc !== 1'b1 && k < max) begin
         step(1);
         k++;
      end
      push(tag, 1);
      check({31'd0, count_tc});
   endtask
   task automatic wait_done(string tag, int max);
      int k = 0;
      while (done !== 1'b1 && k < max) begin
         step(1);
         k++;
      end
      push(tag, 1);
      check({31'd0, done});
   endtask
   initial begin
      step(3);
      reset = 1'b0;
      step(1);
      push("reset_outs", mk(0, 0, 0, 0, 0, 0)); check(outs());
      // reset mid-run
      start = 1'b1; oneshot = 1'b0; prescale = 8'd3; step(1); start = 1'b0;
      push("t1_clear", mk(0, 1, 1, 0, 0, 0)); check(outs());
      step(10);
      push("t1_busy", 1); check({31'd0, busy});
      reset = 1'b1; step(1);
      push("t1_reset_outs", mk(0, 0, 0, 0, 0, 0)); check(outs());
      reset = 1'b0; e0 = en_seen; step(10);
      push("t1_no_en", 0); check(en_seen - e0);
      push("t1_cnt", 0); check({16'd0, cnt});
      // one-shot, prescale 0, full 65536-count run
      oneshot = 1'b1; prescale = 8'd0; start = 1'b1; step(1); start = 1'b0;
      e0 = en_seen;
      push("t2_clear", mk(0, 1, 1, 0, 0, 0)); check(outs());
      step(1);
      push("t2_first_en", mk(1, 0, 1, 0, 0, 0)); check(outs());
      wait_done("t2_done_seen", 70000);
      push("t2_en_count", 65536); check(en_seen - e0);
      push("t2_done_outs", mk(0, 0, 0, 1, 1, 1)); check(outs());
      push("t2_cnt", 0); check({16'd0, cnt});
      step(1);
      push("t2_done_once", mk(0, 0, 0, 0, 1, 1)); check(outs());
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
      // periodic, prescale 1
      oneshot = 1'b0; prescale = 8'd1; start = 1'b1; step(1); start = 1'b0;
      d0 = done_seen;
      for (int i = 0; i < 4; i++) push("t3_alt_en", i % 2);
      for (int i = 0; i < 4; i++) begin
         step(1);
         check({31'd0, count_en});
      end
      for (int k = 1; k <= 3; k++) begin
         load = 1'b1; step(1); load = 1'b0;
         wait_tc("t3_tc_seen", 4);
         step(1);
         push("t3_wrap", k); check({24'd0, wrap_cnt});
      end
      push("t3_busy", 1); check({31'd0, busy});
      push("t3_no_done", 0); check(done_seen - d0);
      t0 = tc_seen; load = 1'b1; n = 0;
      while (wrap_cnt !== 8'd255 && n < 1000) begin
         step(1);
         n++;
      end
      push("t3_tc_to_sat", 252); check(tc_seen - t0);
      wait_tc("t3_tc_sat", 4);
      step(1);
      load = 1'b0;
      push("t3_wrap_sat", 255); check({24'd0, wrap_cnt});
      push("t3_irq", 1); check({31'd0, irq});
      stop = 1'b1; step(1); stop = 1'b0;
      push("t3_stop", mk(0, 0, 0, 0, 1, 255)); check(outs());
      // start and stop together from IDLE
      c0 = clr_seen; start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
      push("t4_idle", mk(0, 0, 0, 0, 1, 255)); check(outs());
      step(1);
      push("t4_no_clear", 0); check(clr_seen - c0);
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
      push("t4_ack_clears", 0); check({31'd0, irq});
      // stop together with one-shot terminal count
      oneshot = 1'b1; prescale = 8'd0; start = 1'b1; step(1); start = 1'b0;
      step(1); load = 1'b1; step(1); load = 1'b0;
      d0 = done_seen;
      push("t5_tc", 1); check({31'd0, count_tc});
      stop = 1'b1; step(1); stop = 1'b0;
      push("t5_stop_tc", mk(0, 0, 0, 0, 1, 1)); check(outs());
      step(1);
      push("t5_no_done", 0); check(done_seen - d0);
      // irq_ack together with terminal count
      oneshot = 1'b0; prescale = 8'd0; start = 1'b1; step(1); start = 1'b0;
      step(1); load = 1'b1; step(1); load = 1'b0;
      push("t6_tc", 1); check({31'd0, count_tc});
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
      push("t6_set_wins", 1); check({31'd0, irq});
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
      push("t6_ack_clears", 0); check({31'd0, irq});
      // restart mid-run with prescale 0 -> 2
      prescale = 8'd2; start = 1'b1; step(1); start = 1'b0;
      push("t7_restart", mk(0, 1, 1, 0, 0, 0)); check(outs());
      for (int i = 1; i <= 9; i++) push("t7_en_period3", {31'd0, i % 3 == 0});
      for (int i = 1; i <= 9; i++) begin
         step(1);
         check({31'd0, count_en});
      end
      push("t7_cnt", 2); check({16'd0, cnt});
      // restart in the same cycle as terminal count
      load = 1'b1; step(1); load = 1'b0;
      wait_tc("t7_tc_seen", 3);
      prescale = 8'd0; start = 1'b1; step(1); start = 1'b0;
      push("t7_restart_tc", mk(0, 1, 1, 0, 1, 0)); check(outs());
      step(2); stop = 1'b1; step(1); stop = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
